// File: rtl/mcctrl_pkg.sv
// Shared types and encodings for the multi-cycle RISC-V sequencer (multicycle_ctrl).
package mcctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      DECODE,
      EXEC,
      MEM,
      WB,
      HALT
   } state_t;

   typedef enum logic [2:0] {
      ADD,
      ADDI,
      LW,
      SW,
      BNE,
      ILL
   } iclass_t;

   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_WORD = 3'b010;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [6:0] F7_ADD  = 7'b0000000;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;

   localparam logic [1:0] FLT_NONE    = 2'b00;
   localparam logic [1:0] FLT_ILLEGAL = 2'b01;
   localparam logic [1:0] FLT_TIMEOUT = 2'b10;

   // Classes that take the ALU immediate operand path.
   function automatic logic uses_imm(input iclass_t c);
      return (c == ADDI) || (c == LW) || (c == SW);
   endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: maps an instruction word onto iclass_t.
module mc_decode
   import mcctrl_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] instr,
   output iclass_t          iclass
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic       unused_instr;

   assign opcode       = instr[6:0];
   assign funct3       = instr[14:12];
   assign funct7       = instr[31:25];
   assign unused_instr = ^instr;

   always_comb begin
      iclass = ILL;
      case (opcode)
         OP_RTYPE:  if (funct3 == F3_ADD && funct7 == F7_ADD) iclass = ADD;
         OP_IMM:    if (funct3 == F3_ADD)  iclass = ADDI;
         OP_LOAD:   if (funct3 == F3_WORD) iclass = LW;
         OP_STORE:  if (funct3 == F3_WORD) iclass = SW;
         OP_BRANCH: if (funct3 == F3_BNE)  iclass = BNE;
         default:   iclass = ILL;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer: FETCH/DECODE/EXEC/MEM/WB with memory req/ready handshake and fault halt.
// Optional MCCTRL_PERF_EN adds retired-instruction and active-cycle counters.
module multicycle_ctrl
   import mcctrl_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int MEM_TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] instr,
   input  logic             EQ,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             mem_we,
   output logic             IRWrite,
   output logic             PCWrite,
   output logic             PCsrc,
   output logic             RegWrite,
   output logic             ALUsrc,
   output logic [2:0]       ALUctrl,
   output logic [1:0]       ImmSrc,
   output logic             ResultSrc,
   output logic             halted,
   output logic [1:0]       fault,
   output logic [2:0]       state_dbg
`ifdef MCCTRL_PERF_EN
   ,
   output logic [31:0]      retired,
   output logic [31:0]      cycles
`endif
);

   // Handshake: a memory transfer completes in the cycle where mem_req and mem_ready are both high.
   localparam int TW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
   localparam logic [TW-1:0] T_LAST = TW'(MEM_TIMEOUT - 1);

   state_t        state;
   iclass_t       iclass_q;
   iclass_t       dec_class;
   logic [TW-1:0] tcnt;

   mc_decode #(.WIDTH(WIDTH)) u_decode (
      .instr  (instr),
      .iclass (dec_class)
   );

   assign state_dbg = state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         iclass_q <= ILL;
         tcnt     <= '0;
         halted   <= 1'b0;
         fault    <= FLT_NONE;
      end else begin
         case (state)
            IDLE: state <= FETCH;
            FETCH, MEM: begin
               if (mem_ready) begin
                  tcnt <= '0;
                  if (state == FETCH)      state <= DECODE;
                  else if (iclass_q == SW) state <= FETCH;
                  else                     state <= WB;
               end else if (tcnt == T_LAST) begin
                  tcnt   <= '0;
                  state  <= HALT;
                  halted <= 1'b1;
                  fault  <= FLT_TIMEOUT;
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
            end
            DECODE: begin
               iclass_q <= dec_class;
               if (dec_class == ILL) begin
                  state  <= HALT;
                  halted <= 1'b1;
                  fault  <= FLT_ILLEGAL;
               end else begin
                  state <= EXEC;
               end
            end
            EXEC: begin
               case (iclass_q)
                  BNE:     state <= FETCH;
                  LW, SW:  state <= MEM;
                  default: state <= WB;
               endcase
            end
            WB:      state <= FETCH;
            HALT:    state <= HALT;
            default: state <= HALT;
         endcase
      end
   end

   // Strobes decode from registered state/class; EQ and mem_ready qualify within the same cycle.
   always_comb begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      IRWrite   = 1'b0;
      PCWrite   = 1'b0;
      PCsrc     = 1'b0;
      RegWrite  = 1'b0;
      ALUsrc    = 1'b0;
      ALUctrl   = ALU_ADD;
      ImmSrc    = IMM_I;
      ResultSrc = 1'b0;
      case (state)
         FETCH: begin
            mem_req = 1'b1;
            IRWrite = mem_ready;
         end
         EXEC: begin
            ALUsrc = uses_imm(iclass_q);
            case (iclass_q)
               SW:      ImmSrc = IMM_S;
               BNE:     ImmSrc = IMM_B;
               default: ImmSrc = IMM_I;
            endcase
            if (iclass_q == BNE) begin
               ALUctrl = ALU_SUB;
               PCWrite = 1'b1;
               PCsrc   = ~EQ;
            end
         end
         MEM: begin
            mem_req = 1'b1;
            mem_we  = (iclass_q == SW);
            PCWrite = mem_ready && (iclass_q == SW);
         end
         WB: begin
            RegWrite  = 1'b1;
            ResultSrc = (iclass_q == LW);
            PCWrite   = 1'b1;
         end
         default: ;
      endcase
   end

`ifdef MCCTRL_PERF_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         retired <= '0;
         cycles  <= '0;
      end else begin
         if (PCWrite) retired <= retired + 32'd1;
         if (state != IDLE && state != HALT) cycles <= cycles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl; one task per scenario, per-cycle expected vectors.
module tb_multicycle_ctrl;

   logic        clk;
   logic        rst;
   logic [31:0] instr;
   logic        EQ;
   logic        mem_ready;
   logic        mem_req, mem_we, IRWrite, PCWrite, PCsrc, RegWrite, ALUsrc, ResultSrc, halted;
   logic [2:0]  ALUctrl;
   logic [1:0]  ImmSrc;
   logic [1:0]  fault;
   logic [2:0]  state_dbg;
`ifdef MCCTRL_PERF_EN
   logic [31:0] retired, cycles;
`endif

   multicycle_ctrl #(.WIDTH(32), .MEM_TIMEOUT(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .instr     (instr),
      .EQ        (EQ),
      .mem_ready (mem_ready),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .IRWrite   (IRWrite),
      .PCWrite   (PCWrite),
      .PCsrc     (PCsrc),
      .RegWrite  (RegWrite),
      .ALUsrc    (ALUsrc),
      .ALUctrl   (ALUctrl),
      .ImmSrc    (ImmSrc),
      .ResultSrc (ResultSrc),
      .halted    (halted),
      .fault     (fault),
      .state_dbg (state_dbg)
`ifdef MCCTRL_PERF_EN
      ,
      .retired   (retired),
      .cycles    (cycles)
`endif
   );

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Output vector: {mem_req,mem_we,IRWrite,PCWrite,PCsrc,RegWrite,ALUsrc,ALUctrl,ImmSrc,ResultSrc,halted,fault}
   logic [15:0] obs;
   assign obs = {mem_req, mem_we, IRWrite, PCWrite, PCsrc, RegWrite, ALUsrc,
                 ALUctrl, ImmSrc, ResultSrc, halted, fault};

   localparam logic [15:0] E_NONE = 16'h0000;
   localparam logic [15:0] B_MREQ = 16'h8000;
   localparam logic [15:0] B_MWE  = 16'h4000;
   localparam logic [15:0] B_IRW  = 16'h2000;
   localparam logic [15:0] B_PCW  = 16'h1000;
   localparam logic [15:0] B_PCS  = 16'h0800;
   localparam logic [15:0] B_RW   = 16'h0400;
   localparam logic [15:0] B_ASRC = 16'h0200;
   localparam logic [15:0] B_SUB  = 16'h0040;
   localparam logic [15:0] B_IMMB = 16'h0020;
   localparam logic [15:0] B_IMMS = 16'h0010;
   localparam logic [15:0] B_RS   = 16'h0008;
   localparam logic [15:0] B_HALT = 16'h0004;
   localparam logic [15:0] B_FTO  = 16'h0002;
   localparam logic [15:0] B_FILL = 16'h0001;

   localparam logic [31:0] I_ADDI = 32'h00500513;  // addi x10,x0,5
   localparam logic [31:0] I_BNE  = 32'h00209463;  // bne x1,x2,8
   localparam logic [31:0] I_LW   = 32'h0000A283;  // lw x5,0(x1)
   localparam logic [31:0] I_SW   = 32'h0050A223;  // sw x5,4(x1)
   localparam logic [31:0] I_ADD  = 32'h002081B3;  // add x3,x1,x2
   localparam logic [31:0] I_BAD  = 32'hFFFFFFFF;

   // Scoreboard
   logic [15:0] exp_q[$];
   logic [33:0] stim_q[$];
   logic [15:0] exp_v;
   int          vecs;
   int          miscompares;

   // Driver tasks
   task automatic push(input logic [31:0] i, input logic e, input logic r, input logic [15:0] x);
      stim_q.push_back({i, e, r});
      exp_q.push_back(x);
   endtask

   task automatic start();
      @(negedge clk);
      rst       = 1'b1;
      mem_ready = 1'b0;
      EQ        = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst       = 1'b1;
      mem_ready = 1'b1;
      instr     = I_ADDI;
      #1;
      vecs++;
      if (obs !== E_NONE) begin
         miscompares++;
         $display("FAIL reset_hold obs=%h exp=%h", obs, E_NONE);
      end
      @(negedge clk);
      rst       = 1'b0;
      mem_ready = 1'b0;
      #1;
      vecs++;
      if (obs !== E_NONE || state_dbg !== 3'd0) begin
         miscompares++;
         $display("FAIL reset_idle obs=%h state=%0d exp=%h state=0", obs, state_dbg, E_NONE);
      end
      @(negedge clk);
      #1;
      vecs++;
      if (obs !== B_MREQ) begin
         miscompares++;
         $display("FAIL reset_fetch obs=%h exp=%h", obs, B_MREQ);
      end
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      vecs++;
      if (obs !== E_NONE) begin
         miscompares++;
         $display("FAIL reset_async obs=%h exp=%h", obs, E_NONE);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      vecs++;
      if (obs !== E_NONE) begin
         miscompares++;
         $display("FAIL reset_idle2 obs=%h exp=%h", obs, E_NONE);
      end
      @(negedge clk);
      #1;
      vecs++;
      if (obs !== B_MREQ) begin
         miscompares++;
         $display("FAIL reset_fetch2 obs=%h exp=%h", obs, B_MREQ);
      end
   endtask

   task automatic test_addi();
      start();
      push(I_ADDI, 1'b0, 1'b1, E_NONE);
      push(I_ADDI, 1'b0, 1'b1, B_MREQ | B_IRW);
      push(I_ADDI, 1'b0, 1'b1, E_NONE);
      push(I_ADDI, 1'b0, 1'b1, B_ASRC);
      push(I_ADDI, 1'b0, 1'b1, B_RW | B_PCW);
      push(I_ADDI, 1'b0, 1'b1, B_MREQ | B_IRW);
      for (int n = 0; exp_q.size() > 0; n++) begin
         {instr, EQ, mem_ready} = stim_q.pop_front();
         #1;
         exp_v = exp_q.pop_front();
         vecs++;
         if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL addi cyc%0d obs=%h exp=%h", n, obs, exp_v);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_bne();
      start();
      push(I_BNE, 1'b0, 1'b1, E_NONE);
      push(I_BNE, 1'b0, 1'b1, B_MREQ | B_IRW);
      push(I_BNE, 1'b0, 1'b1, E_NONE);
      push(I_BNE, 1'b0, 1'b1, B_SUB | B_IMMB | B_PCW | B_PCS);
      push(I_BNE, 1'b1, 1'b1, B_MREQ | B_IRW);
      push(I_BNE, 1'b1, 1'b1, E_NONE);
      push(I_BNE, 1'b1, 1'b1, B_SUB | B_IMMB | B_PCW);
      push(I_BNE, 1'b1, 1'b1, B_MREQ | B_IRW);
      for (int n = 0; exp_q.size() > 0; n++) begin
         {instr, EQ, mem_ready} = stim_q.pop_front();
         #1;
         exp_v = exp_q.pop_front();
         vecs++;
         if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL bne cyc%0d obs=%h exp=%h", n, obs, exp_v);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_lw_wait();
      start();
      push(I_LW, 1'b0, 1'b1, E_NONE);
      push(I_LW, 1'b0, 1'b1, B_MREQ | B_IRW);
      push(I_LW, 1'b0, 1'b1, E_NONE);
      push(I_LW, 1'b0, 1'b0, B_ASRC);
      push(I_LW, 1'b0, 1'b0, B_MREQ);
      push(I_LW, 1'b0, 1'b0, B_MREQ);
      push(I_LW, 1'b0, 1'b0, B_MREQ);
      push(I_LW, 1'b0, 1'b1, B_MREQ);
      push(I_LW, 1'b0, 1'b1, B_RW | B_PCW | B_RS);
      push(I_LW, 1'b0, 1'b0, B_MREQ);
      for (int n = 0; exp_q.size() > 0; n++) begin
         {instr, EQ, mem_ready} = stim_q.pop_front();
         #1;
         exp_v = exp_q.pop_front();
         vecs++;
         if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL lw_wait cyc%0d obs=%h exp=%h", n, obs, exp_v);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_back_to_back();
      start();
      push(I_ADD, 1'b0, 1'b1, E_NONE);
      push(I_ADD, 1'b0, 1'b1, B_MREQ | B_IRW);
      push(I_ADD, 1'b0, 1'b1, E_NONE);
      push(I_ADD, 1'b0, 1'b1, E_NONE);
      push(I_ADD, 1'b0, 1'b1, B_RW | B_PCW);
      push(I_SW,  1'b0, 1'b1, B_MREQ | B_IRW);
      push(I_SW,  1'b0, 1'b1, E_NONE);
      push(I_SW,  1'b0, 1'b0, B_ASRC | B_IMMS);
      push(I_SW,  1'b0, 1'b0, B_MREQ | B_MWE);
      push(I_SW,  1'b0, 1'b1, B_MREQ | B_MWE | B_PCW);
      push(I_BNE, 1'b1, 1'b1, B_MREQ | B_IRW);
      push(I_BNE, 1'b1, 1'b1, E_NONE);
      push(I_BNE, 1'b1, 1'b1, B_SUB | B_IMMB | B_PCW);
      push(I_LW,  1'b0, 1'b1, B_MREQ | B_IRW);
      push(I_LW,  1'b0, 1'b1, E_NONE);
      push(I_LW,  1'b0, 1'b1, B_ASRC);
      push(I_LW,  1'b0, 1'b1, B_MREQ);
      push(I_LW,  1'b0, 1'b1, B_RW | B_PCW | B_RS);
      for (int n = 0; exp_q.size() > 0; n++) begin
         {instr, EQ, mem_ready} = stim_q.pop_front();
         #1;
         exp_v = exp_q.pop_front();
         vecs++;
         if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL back_to_back cyc%0d obs=%h exp=%h", n, obs, exp_v);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_illegal();
      start();
      push(I_BAD, 1'b0, 1'b1, E_NONE);
      push(I_BAD, 1'b0, 1'b1, B_MREQ | B_IRW);
      push(I_BAD, 1'b0, 1'b1, E_NONE);
      for (int k = 0; k < 4; k++) push(I_ADDI, 1'b0, 1'b1, B_HALT | B_FILL);
      for (int n = 0; exp_q.size() > 0; n++) begin
         {instr, EQ, mem_ready} = stim_q.pop_front();
         #1;
         exp_v = exp_q.pop_front();
         vecs++;
         if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL illegal cyc%0d obs=%h exp=%h", n, obs, exp_v);
         end
         @(negedge clk);
      end
      start();
      push(I_ADDI, 1'b0, 1'b1, E_NONE);
      push(I_ADDI, 1'b0, 1'b1, B_MREQ | B_IRW);
      for (int n = 0; exp_q.size() > 0; n++) begin
         {instr, EQ, mem_ready} = stim_q.pop_front();
         #1;
         exp_v = exp_q.pop_front();
         vecs++;
         if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL illegal_recover cyc%0d obs=%h exp=%h", n, obs, exp_v);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_timeout();
      start();
      push(I_ADDI, 1'b0, 1'b0, E_NONE);
      for (int k = 0; k < 16; k++) push(I_ADDI, 1'b0, 1'b0, B_MREQ);
      for (int k = 0; k < 3; k++)  push(I_ADDI, 1'b0, 1'b1, B_HALT | B_FTO);
      for (int n = 0; exp_q.size() > 0; n++) begin
         {instr, EQ, mem_ready} = stim_q.pop_front();
         #1;
         exp_v = exp_q.pop_front();
         vecs++;
         if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL fetch_timeout cyc%0d obs=%h exp=%h", n, obs, exp_v);
         end
         @(negedge clk);
      end
      // Recover, then time out a load in MEM after a 15-cycle wait resets the count once.
      start();
      push(I_LW, 1'b0, 1'b0, E_NONE);
      for (int k = 0; k < 15; k++) push(I_LW, 1'b0, 1'b0, B_MREQ);
      push(I_LW, 1'b0, 1'b1, B_MREQ | B_IRW);
      push(I_LW, 1'b0, 1'b0, E_NONE);
      push(I_LW, 1'b0, 1'b0, B_ASRC);
      for (int k = 0; k < 16; k++) push(I_LW, 1'b0, 1'b0, B_MREQ);
      for (int k = 0; k < 2; k++)  push(I_LW, 1'b0, 1'b1, B_HALT | B_FTO);
      for (int n = 0; exp_q.size() > 0; n++) begin
         {instr, EQ, mem_ready} = stim_q.pop_front();
         #1;
         exp_v = exp_q.pop_front();
         vecs++;
         if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL mem_timeout cyc%0d obs=%h exp=%h", n, obs, exp_v);
         end
         @(negedge clk);
      end
   endtask

   initial begin
      vecs        = 0;
      miscompares = 0;
      rst         = 1'b1;
      instr       = 32'h0;
      EQ          = 1'b0;
      mem_ready   = 1'b0;
      test_reset();
      test_addi();
      test_bne();
      test_lw_wait();
      test_back_to_back();
      test_illegal();
      test_timeout();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
      $finish;
   end

endmodule
